game_event_arbiter: RTL and testbench
=====================================

Name: game_event_arbiter

Overview:
- Multi-object successor to the single-ball collision/game controller.
- Per pixel, classifies overlaps between NUM_OBJ sprite channels and the tile map/border.
- Latches at most one event of each kind per object per frame, tracks gifts and lives, and runs the level state machine (IDLE/PLAY/WIN/LOSE).
- Sits between the sprite/tile drawing units and the sprite movement and tile-memory logic.

Parameters:
NUM_OBJ, 2, number of moving sprite channels; channel 0 is the player, channels 1..NUM_OBJ-1 are hazards
NUM_GIFTS, 8, gift count loaded at level start
LIVES, 3, lives loaded at level start
TYPE_W, 2, tile type code width

Ports:
clk  in  1  system clock
resetN  in  1  reset, synchronous, active-low
startOfFrame  in  1  one-cycle pulse at frame start
startGame  in  1  one-cycle level start/restart request
draw_obj  in  NUM_OBJ  per-object drawing request, current pixel
draw_tile  in  1  tile drawing request, current pixel
draw_border  in  1  border drawing request, current pixel
tile_type  in  TYPE_W  tile code of current pixel
edge_fatal  in  1  current border pixel is the fatal (bottom) edge
collision  out  NUM_OBJ  combinational per-pixel solid contact per object
hit_pulse  out  NUM_OBJ  registered, at most one pulse per object per frame
gift_pulse  out  1  registered, at most one pulse per frame
gifts_left  out  $clog2(NUM_GIFTS+1)  remaining gifts
lives_left  out  $clog2(LIVES+1)  remaining lives
hole_open  out  1  gifts_left==0 while in PLAY
game_state  out  2  IDLE=0, PLAY=1, WIN=2, LOSE=3
victory  out  1  one-cycle pulse on entry to WIN
loss  out  1  one-cycle pulse on entry to LOSE
respawn  out  1  one-cycle pulse when a life is lost but lives remain

Behaviour:
- Pixel classification (combinational):
  - solid = (draw_tile & type==FLOOR) | (draw_tile & type==HOLE & !hole_open) | draw_border.
  - collision[i] = draw_obj[i] & solid, independent of game_state.
  - Gift event: draw_obj[0] & draw_tile & type==GIFT.
  - Hole event: draw_obj[0] & draw_tile & type==HOLE & hole_open.
  - Fatal event: draw_obj[0] & ((draw_border & edge_fatal) | |draw_obj[NUM_OBJ-1:1]).
- Per-frame flags, one per object hit plus gift/hole/fatal:
  - A flag sets on its event while it is clear.
  - startOfFrame clears all flags. If an event coincides with startOfFrame, it sets the flag for the new frame (clear first, then set).
  - Event flags and pulses update only in PLAY.
- hit_pulse[i]: asserted one cycle after the first collision[i] pixel of the frame.
- gift_pulse: asserted one cycle after the first gift pixel of the frame. Same cycle as the pulse, gifts_left decrements, saturating at 0.
- Frame resolution at startOfFrame in PLAY uses the flags of the ending frame:
  - hole flag set -> WIN, victory pulse next cycle.
  - else fatal flag set and lives_left==1 -> LOSE, lives_left=0, loss pulse.
  - else fatal flag set -> lives_left-1, respawn pulse, stay PLAY.
  - Hole has priority over fatal.
- FSM:
  - IDLE/WIN/LOSE + startGame -> PLAY, loading gifts_left=NUM_GIFTS and lives_left=LIVES, clearing all flags.
  - startGame in PLAY restarts the level the same way.
  - startGame together with startOfFrame: the restart wins and no resolution occurs.
- Reset (resetN low at a clk edge, including mid-frame or mid-level):
  - game_state=IDLE.
  - All flags, hit_pulse, gift_pulse, victory, loss, respawn = 0.
  - gifts_left=0, lives_left=0, hole_open=0.
- hole_open is 0 outside PLAY. NUM_GIFTS=0 gives hole_open=1 immediately in PLAY.
- All outputs except collision are registered; latency is 1 clk from the triggering pixel or startOfFrame.

Decomposition:
- Package game_pkg holds:
  - Tile codes TILE_BACKGROUND=0, TILE_FLOOR=1, TILE_GIFT=2, TILE_HOLE=3.
  - The game_state enum.
- Sub-module frame_event_latch: inputs clk, resetN, startOfFrame, enable, event; outputs flag and a one-shot pulse.
  - Instantiated NUM_OBJ+3 times (per-object hit, gift, hole, fatal).

Test Plan:
1. startGame, then object 0 on FLOOR pixels at 5 consecutive clocks in one frame -> collision high for 5 clocks; hit_pulse[0] high exactly 1 clock, 1 after the first pixel; next frame repeats once.
2. Gift pixels for object 0 in 3 separate frames, two gift runs within one of them -> gift_pulse 3 times total; gifts_left 8->5.
3. NUM_GIFTS=2: collect both, then object 0 on HOLE -> hole_open=1, no collision; at next startOfFrame state=WIN and victory=1 for 1 clock. Before the gifts, the HOLE pixel gives collision=1 and no win.
4. Object 0 overlaps object 1 in three frames -> respawn pulses at frame ends 1 and 2 (lives 3->2->1); third frame end -> LOSE, loss pulse, lives_left=0.
5. Hole and fatal events in the same frame -> WIN, lives unchanged. Collision on the same cycle as startOfFrame -> hit_pulse in the new frame.
6. resetN low mid-PLAY with flags set -> next clk all registered outputs 0, state IDLE; collision still follows draw inputs.

Source files
------------

// File: rtl/game_pkg.sv
// Shared tile codes, level state encoding and width helper for the game event arbiter.
package game_pkg;

   localparam int unsigned TILE_BACKGROUND = 0;
   localparam int unsigned TILE_FLOOR      = 1;
   localparam int unsigned TILE_GIFT       = 2;
   localparam int unsigned TILE_HOLE       = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } game_state_t;

   // Width of a down-counter holding 0..n; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Once-per-frame event latch: remembers that an event happened this frame and
// emits a single registered pulse on its first occurrence.
module frame_event_latch (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic enable,
   input  logic evt,
   output logic flag,
   output logic pulse
);

   // Clear at frame start, then allow an event on that same cycle to set the
   // flag for the new frame; a low enable holds the latch cleared.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         flag  <= 1'b0;
         pulse <= 1'b0;
      end else if (!enable) begin
         flag  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         pulse <= evt & (startOfFrame | ~flag);
         flag  <= evt | (flag & ~startOfFrame);
      end
   end

endmodule

// File: rtl/game_event_arbiter.sv
// Per-pixel collision classification, per-frame event latching, gift/lives
// bookkeeping and the level state machine for a multi-sprite game.
module game_event_arbiter
   import game_pkg::*;
#(
   parameter int NUM_OBJ   = 2,
   parameter int NUM_GIFTS = 8,
   parameter int LIVES     = 3,
   parameter int TYPE_W    = 2
) (
   input  logic                        clk,
   input  logic                        resetN,
   input  logic                        startOfFrame,
   input  logic                        startGame,
   input  logic [NUM_OBJ-1:0]          draw_obj,
   input  logic                        draw_tile,
   input  logic                        draw_border,
   input  logic [TYPE_W-1:0]           tile_type,
   input  logic                        edge_fatal,
   output logic [NUM_OBJ-1:0]          collision,
   output logic [NUM_OBJ-1:0]          hit_pulse,
   output logic                        gift_pulse,
   output logic [cnt_w(NUM_GIFTS)-1:0] gifts_left,
   output logic [cnt_w(LIVES)-1:0]     lives_left,
   output logic                        hole_open,
   output logic [1:0]                  game_state,
   output logic                        victory,
   output logic                        loss,
   output logic                        respawn
);

   localparam int GW = cnt_w(NUM_GIFTS);
   localparam int LW = cnt_w(LIVES);

   game_state_t state;

   logic is_floor, is_gift, is_hole, solid;
   logic gift_evt, hole_evt, fatal_evt;
   logic en, gift_set;
   logic gift_flag, hole_flag, fatal_flag;
   logic [NUM_OBJ-1:0] unused_hit_flag;
   logic unused_hole_pulse, unused_fatal_pulse;

   // Pixel classification and event decode.
   always_comb begin
      is_floor  = draw_tile & (tile_type == TYPE_W'(TILE_FLOOR));
      is_gift   = draw_tile & (tile_type == TYPE_W'(TILE_GIFT));
      is_hole   = draw_tile & (tile_type == TYPE_W'(TILE_HOLE));
      solid     = is_floor | (is_hole & ~hole_open) | draw_border;
      collision = draw_obj & {NUM_OBJ{solid}};
      gift_evt  = draw_obj[0] & is_gift;
      hole_evt  = draw_obj[0] & is_hole & hole_open;
      fatal_evt = draw_obj[0] & ((draw_border & edge_fatal) | (|draw_obj[NUM_OBJ-1:1]));
   end

   // Latches run only while playing; a restart cycle holds them cleared.
   assign en       = (state == ST_PLAY) & ~startGame;
   // Mirrors the gift latch's own set condition so the count moves with the pulse.
   assign gift_set = en & gift_evt & (startOfFrame | ~gift_flag);

   assign hole_open  = (state == ST_PLAY) && (gifts_left == '0);
   assign game_state = state;

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_hit
      frame_event_latch u_hit (
         .clk          (clk),
         .resetN       (resetN),
         .startOfFrame (startOfFrame),
         .enable       (en),
         .evt          (collision[i]),
         .flag         (unused_hit_flag[i]),
         .pulse        (hit_pulse[i])
      );
   end

   frame_event_latch u_gift (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .enable       (en),
      .evt          (gift_evt),
      .flag         (gift_flag),
      .pulse        (gift_pulse)
   );

   frame_event_latch u_hole (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .enable       (en),
      .evt          (hole_evt),
      .flag         (hole_flag),
      .pulse        (unused_hole_pulse)
   );

   frame_event_latch u_fatal (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .enable       (en),
      .evt          (fatal_evt),
      .flag         (fatal_flag),
      .pulse        (unused_fatal_pulse)
   );

   // Level FSM, gift/lives counters and frame-end resolution pulses.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state      <= ST_IDLE;
         gifts_left <= '0;
         lives_left <= '0;
         victory    <= 1'b0;
         loss       <= 1'b0;
         respawn    <= 1'b0;
      end else begin
         victory <= 1'b0;
         loss    <= 1'b0;
         respawn <= 1'b0;
         if (startGame) begin
            state      <= ST_PLAY;
            gifts_left <= GW'(NUM_GIFTS);
            lives_left <= LW'(LIVES);
         end else if (state == ST_PLAY) begin
            if (gift_set && (gifts_left != '0))
               gifts_left <= gifts_left - 1'b1;
            if (startOfFrame) begin
               if (hole_flag) begin
                  state   <= ST_WIN;
                  victory <= 1'b1;
               end else if (fatal_flag) begin
                  if (lives_left <= LW'(1)) begin
                     state      <= ST_LOSE;
                     lives_left <= '0;
                     loss       <= 1'b1;
                  end else begin
                     lives_left <= lives_left - 1'b1;
                     respawn    <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_game_event_arbiter.sv
// Directed self-checking bench: default instance (8 gifts, 3 lives) and a
// two-gift instance sharing the same pixel stimulus.
module tb_game_event_arbiter;

   localparam logic [1:0] T_BG    = 2'd0;
   localparam logic [1:0] T_FLOOR = 2'd1;
   localparam logic [1:0] T_GIFT  = 2'd2;
   localparam logic [1:0] T_HOLE  = 2'd3;

   logic       clk = 1'b0;
   logic       resetN;
   logic       sof;
   logic       start_game;
   logic [1:0] draw_obj;
   logic       draw_tile;
   logic       draw_border;
   logic [1:0] tile_type;
   logic       edge_fatal;

   logic [1:0] coll_a, hit_a, state_a, lives_a;
   logic       gift_a, hole_a, vic_a, loss_a, resp_a;
   logic [3:0] gifts_a;

   logic [1:0] coll_b, hit_b, state_b, lives_b, gifts_b;
   logic       gift_b, hole_b, vic_b, loss_b, resp_b;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned n_hit0  = 0;
   int unsigned n_gift  = 0;

   game_event_arbiter dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .startGame(start_game),
      .draw_obj(draw_obj), .draw_tile(draw_tile), .draw_border(draw_border),
      .tile_type(tile_type), .edge_fatal(edge_fatal),
      .collision(coll_a), .hit_pulse(hit_a), .gift_pulse(gift_a),
      .gifts_left(gifts_a), .lives_left(lives_a), .hole_open(hole_a),
      .game_state(state_a), .victory(vic_a), .loss(loss_a), .respawn(resp_a)
   );

   game_event_arbiter #(.NUM_GIFTS(2)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .startGame(start_game),
      .draw_obj(draw_obj), .draw_tile(draw_tile), .draw_border(draw_border),
      .tile_type(tile_type), .edge_fatal(edge_fatal),
      .collision(coll_b), .hit_pulse(hit_b), .gift_pulse(gift_b),
      .gifts_left(gifts_b), .lives_left(lives_b), .hole_open(hole_b),
      .game_state(state_b), .victory(vic_b), .loss(loss_b), .respawn(resp_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (hit_a[0]) n_hit0++;
      if (gift_a)   n_gift++;
   endtask

   task automatic pix(input logic [1:0] obj, input logic tile, input logic [1:0] ty);
      draw_obj    = obj;
      draw_tile   = tile;
      tile_type   = ty;
      draw_border = 1'b0;
      edge_fatal  = 1'b0;
   endtask

   task automatic idle();
      pix(2'b00, 1'b0, T_BG);
   endtask

   task automatic frame_start();
      sof = 1'b1;
      cyc();
      sof = 1'b0;
   endtask

   task automatic restart();
      start_game = 1'b1;
      cyc();
      start_game = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      resetN = 1'b0; sof = 1'b0; start_game = 1'b0;
      idle();
      cyc(); cyc();
      chk("rst_state", state_a, 0);
      chk("rst_gifts", gifts_a, 0);
      chk("rst_lives", lives_a, 0);
      chk("rst_hole", hole_a, 0);
      chk("rst_hit", hit_a, 0);
      chk("rst_state_b", state_b, 0);
      resetN = 1'b1;

      // 1: floor contact, one hit pulse per frame
      restart();
      chk("start_state", state_a, 1);
      chk("start_gifts", gifts_a, 8);
      chk("start_lives", lives_a, 3);
      chk("start_hole", hole_a, 0);
      chk("start_gifts_b", gifts_b, 2);
      frame_start();
      n_hit0 = 0;
      for (int k = 0; k < 5; k++) begin
         pix(2'b01, 1'b1, T_FLOOR);
         #1;
         chk("floor_coll", coll_a, 2'b01);
         cyc();
         chk("floor_hit0", hit_a[0], (k == 0));
      end
      idle();
      cyc();
      chk("hit0_count_f1", n_hit0, 1);
      pix(2'b10, 1'b1, T_FLOOR);
      #1;
      chk("obj1_coll", coll_a, 2'b10);
      cyc();
      chk("obj1_hit", hit_a, 2'b10);
      idle();
      frame_start();
      pix(2'b01, 1'b1, T_FLOOR);
      cyc(); cyc(); cyc();
      idle();
      cyc();
      chk("hit0_count_f2", n_hit0, 2);
      pix(2'b01, 1'b0, T_BG);
      draw_border = 1'b1;
      #1;
      chk("border_coll", coll_a, 2'b01);
      cyc();
      idle();
      frame_start();
      chk("no_fatal_lives", lives_a, 3);

      // 2: gifts, at most one per frame
      n_gift = 0;
      frame_start();
      pix(2'b01, 1'b1, T_GIFT);
      #1;
      chk("gift_no_coll", coll_a, 0);
      cyc();
      chk("gift_pulse1", gift_a, 1);
      chk("gifts_7", gifts_a, 7);
      cyc();
      chk("gift_pulse_once", gift_a, 0);
      idle(); cyc();
      pix(2'b01, 1'b1, T_GIFT); cyc(); cyc();
      idle(); cyc();
      chk("gift_run2_count", n_gift, 1);
      chk("gift_run2_gifts", gifts_a, 7);
      frame_start();
      pix(2'b01, 1'b1, T_GIFT); cyc();
      idle();
      frame_start();
      pix(2'b01, 1'b1, T_GIFT); cyc();
      idle(); cyc();
      chk("gift_total", n_gift, 3);
      chk("gifts_5", gifts_a, 5);
      chk("hole_closed", hole_a, 0);

      // 3: two-gift level, hole closed then open
      restart();
      frame_start();
      pix(2'b01, 1'b1, T_HOLE);
      #1;
      chk("hole_closed_coll", coll_b, 2'b01);
      cyc();
      idle();
      frame_start();
      chk("no_win_closed", state_b, 1);
      chk("no_vic_closed", vic_b, 0);
      pix(2'b01, 1'b1, T_GIFT); cyc();
      idle();
      chk("gifts_b_1", gifts_b, 1);
      frame_start();
      pix(2'b01, 1'b1, T_GIFT); cyc();
      idle();
      chk("gifts_b_0", gifts_b, 0);
      chk("hole_open_b", hole_b, 1);
      pix(2'b01, 1'b1, T_HOLE);
      #1;
      chk("hole_open_coll", coll_b, 0);
      cyc();
      idle();
      chk("win_waits_sof", state_b, 1);
      frame_start();
      chk("win_state", state_b, 2);
      chk("victory_pulse", vic_b, 1);
      cyc();
      chk("victory_once", vic_b, 0);
      chk("hole_shut_win", hole_b, 0);

      // 4: overlaps cost lives
      frame_start();
      pix(2'b11, 1'b0, T_BG);
      #1;
      chk("overlap_no_coll", coll_a, 0);
      cyc();
      idle();
      frame_start();
      chk("respawn1", resp_a, 1);
      chk("lives_2", lives_a, 2);
      chk("still_play", state_a, 1);
      cyc();
      chk("respawn_once", resp_a, 0);
      pix(2'b11, 1'b0, T_BG); cyc();
      idle();
      frame_start();
      chk("respawn2", resp_a, 1);
      chk("lives_1", lives_a, 1);
      pix(2'b01, 1'b0, T_BG);
      draw_border = 1'b1; edge_fatal = 1'b1;
      cyc();
      idle();
      frame_start();
      chk("lose_state", state_a, 3);
      chk("loss_pulse", loss_a, 1);
      chk("lives_0", lives_a, 0);
      chk("no_respawn_lose", resp_a, 0);
      cyc();
      chk("loss_once", loss_a, 0);

      // 5: hole beats fatal; coincident frame-start hit; restart beats resolution
      restart();
      frame_start();
      pix(2'b01, 1'b1, T_GIFT); cyc();
      idle();
      frame_start();
      pix(2'b01, 1'b1, T_GIFT); cyc();
      idle();
      chk("hole_open_b2", hole_b, 1);
      pix(2'b11, 1'b1, T_HOLE);
      #1;
      chk("hole_fatal_coll", coll_b, 0);
      cyc();
      idle();
      frame_start();
      chk("hole_prio_state", state_b, 2);
      chk("hole_prio_vic", vic_b, 1);
      chk("hole_prio_lives", lives_b, 3);
      chk("hole_prio_resp", resp_b, 0);
      chk("a_fatal_lives", lives_a, 2);
      chk("a_fatal_resp", resp_a, 1);
      pix(2'b01, 1'b1, T_FLOOR);
      cyc();
      chk("pre_sof_hit", hit_a[0], 1);
      sof = 1'b1;
      cyc();
      sof = 1'b0;
      chk("sof_same_cycle_hit", hit_a[0], 1);
      cyc();
      chk("sof_hit_once", hit_a[0], 0);
      pix(2'b11, 1'b0, T_BG); cyc();
      idle();
      sof = 1'b1; start_game = 1'b1;
      cyc();
      sof = 1'b0; start_game = 1'b0;
      chk("restart_wins_lives", lives_a, 3);
      chk("restart_wins_resp", resp_a, 0);
      chk("restart_wins_state", state_a, 1);

      // 6: reset mid-level
      pix(2'b01, 1'b1, T_FLOOR);
      cyc();
      resetN = 1'b0;
      #1;
      chk("rst_coll_live", coll_a, 2'b01);
      cyc();
      chk("rst2_state", state_a, 0);
      chk("rst2_hit", hit_a, 0);
      chk("rst2_gift", gift_a, 0);
      chk("rst2_gifts", gifts_a, 0);
      chk("rst2_lives", lives_a, 0);
      chk("rst2_hole", hole_a, 0);
      chk("rst2_flags", {vic_a, loss_a, resp_a}, 0);
      chk("rst2_state_b", state_b, 0);
      chk("rst2_coll", coll_a, 2'b01);
      resetN = 1'b1;
      idle();
      restart();
      pix(2'b01, 1'b1, T_FLOOR);
      cyc();
      chk("flag_cleared_by_reset", hit_a[0], 1);
      idle();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
